// File: rtl/hdr_pkg.sv
// Shared constants, RGB565 field widths and FSM encoding for the HDR frame reader.
// unpack_pixel() decodes pixel k of a 128-bit word.
package hdr_pkg;

    localparam logic [24:0] BUF0_BASE        = 25'hE1000;
    localparam logic [24:0] BUF1_BASE        = 25'h106800;
    localparam int unsigned ADDR_STEP        = 4;
    localparam int unsigned WORDS_PER_FRAME  = 38400;
    localparam int unsigned PIXELS_PER_WORD  = 8;
    localparam int unsigned PIXELS_PER_FRAME = 307200;
    localparam int unsigned FIFO_DEPTH       = 4;

    localparam int unsigned RED_W   = 5;
    localparam int unsigned GREEN_W = 6;
    localparam int unsigned BLUE_W  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [RED_W-1:0]   red;
        logic [GREEN_W-1:0] green;
        logic [BLUE_W-1:0]  blue;
    } rgb565_t;

    // Within each 16-bit slot the low byte is "hi" and the high byte is "lo".
    function automatic rgb565_t unpack_pixel(input logic [127:0] word, input logic [2:0] k);
        logic [15:0] slot;
        rgb565_t     px;
        slot     = word[{k, 4'b0000} +: 16];
        px.red   = slot[7:3];
        px.green = {slot[2:0], slot[15:13]};
        px.blue  = slot[12:8];
        return px;
    endfunction

endpackage

// File: rtl/hdr_rd_fifo.sv
// Synchronous word FIFO with flush; Depth must be a power of two (>= 2).
// Flush has priority over push and pop in the same cycle.
module hdr_rd_fifo #(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [Width-1:0]         head,
    output logic [$clog2(Depth):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DepthCnt);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hdr_frame_reader.sv
// Fetches a tone-mapped frame from the idle ping-pong half as 128-bit words and
// delivers one RGB565 pixel per pixel_req, with credit-based read flow control.
module hdr_frame_reader
    import hdr_pkg::*;
#(
    parameter logic [24:0] Buf0Base      = BUF0_BASE,
    parameter logic [24:0] Buf1Base      = BUF1_BASE,
    parameter int unsigned AddrStep      = ADDR_STEP,
    parameter int unsigned WordsPerFrame = WORDS_PER_FRAME,
    parameter int unsigned FifoDepth     = FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         hdr_last_frame,
    input  logic         ram_busy,
    output logic         rd_req,
    output logic [24:0]  rd_address,
    input  logic         rd_valid,
    input  logic [127:0] rd_data,
    input  logic         pixel_req,
    output logic         pixel_valid,
    output logic [4:0]   pixel_red,
    output logic [5:0]   pixel_green,
    output logic [4:0]   pixel_blue,
    output logic         underflow,
    output logic         frame_done
);

    localparam int unsigned CntW = $clog2(FifoDepth) + 1;
    localparam logic [CntW-1:0] DepthCnt   = CntW'(FifoDepth);
    localparam logic [15:0]     WordsTotal = 16'(WordsPerFrame);
    localparam logic [18:0]     LastPixel  = 19'(WordsPerFrame * PIXELS_PER_WORD - 1);
    localparam logic [24:0]     Step       = 25'(AddrStep);

    rd_state_t       state;
    logic [24:0]     base;
    logic [15:0]     words_req;
    logic [CntW-1:0] outstanding;
    logic [CntW-1:0] drop_cnt;
    logic [CntW-1:0] in_flight;
    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   credit_used;
    logic [2:0]      pixel_idx;
    logic [18:0]     pixel_cnt;
    logic [127:0]    fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;
    logic            pixel_ok;
    logic            all_returned;
    rgb565_t         cur_px;

    assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign in_flight    = drop_cnt + outstanding;
    assign rd_req       = ((state == StFill) || (state == StRun)) && !frame_start && !ram_busy
                          && (drop_cnt == '0) && (words_req < WordsTotal)
                          && (credit_used < {1'b0, DepthCnt});
    assign rd_address   = base + Step * {9'd0, words_req};
    // Responses owed to an abandoned frame are swallowed until drop_cnt drains.
    assign fifo_push    = rd_valid && (drop_cnt == '0) && !frame_start;
    assign pixel_ok     = pixel_req && (state == StRun) && !fifo_empty && !frame_start;
    assign fifo_pop     = pixel_ok && (pixel_idx == 3'd7);
    assign all_returned = (words_req == WordsTotal) && (outstanding == '0) && (drop_cnt == '0);
    assign cur_px       = unpack_pixel(fifo_head, pixel_idx);

    hdr_rd_fifo #(
        .Width (128),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rd_data),
        .pop       (fifo_pop),
        .flush     (frame_start),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            base        <= Buf0Base;
            words_req   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            pixel_idx   <= '0;
            pixel_cnt   <= '0;
            pixel_valid <= 1'b0;
            pixel_red   <= '0;
            pixel_green <= '0;
            pixel_blue  <= '0;
            underflow   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            pixel_valid <= 1'b0;
            if (frame_start) begin
                state       <= StFill;
                base        <= hdr_last_frame ? Buf0Base : Buf1Base;
                words_req   <= '0;
                outstanding <= '0;
                drop_cnt    <= (rd_valid && (in_flight != '0)) ? in_flight - 1'b1 : in_flight;
                pixel_idx   <= '0;
                pixel_cnt   <= '0;
                underflow   <= 1'b0;
                if (pixel_req) begin
                    pixel_red   <= '0;
                    pixel_green <= '0;
                    pixel_blue  <= '0;
                end
            end else begin
                if (rd_req) begin
                    words_req <= words_req + 16'd1;
                end
                if (drop_cnt != '0) begin
                    if (rd_valid) begin
                        drop_cnt <= drop_cnt - 1'b1;
                    end
                end else if (rd_req && !rd_valid) begin
                    outstanding <= outstanding + 1'b1;
                end else if (!rd_req && rd_valid && (outstanding != '0)) begin
                    outstanding <= outstanding - 1'b1;
                end

                case (state)
                    StFill: if (fifo_full || all_returned) state <= StRun;
                    StRun:  if (pixel_ok && (pixel_cnt == LastPixel)) state <= StIdle;
                    default: ;
                endcase

                if (pixel_ok) begin
                    pixel_valid <= 1'b1;
                    pixel_red   <= cur_px.red;
                    pixel_green <= cur_px.green;
                    pixel_blue  <= cur_px.blue;
                    pixel_idx   <= pixel_idx + 3'd1;
                    pixel_cnt   <= pixel_cnt + 19'd1;
                    frame_done  <= (pixel_cnt == LastPixel);
                end else if (pixel_req) begin
                    pixel_red   <= '0;
                    pixel_green <= '0;
                    pixel_blue  <= '0;
                    if (state == StRun) begin
                        underflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hdr_frame_reader.sv
// Directed + randomized bench for hdr_frame_reader using a shortened frame,
// a latency-modelled RAM and a word/pixel reference queue.
module tb_hdr_frame_reader;

    localparam int unsigned WPF = 48;
    localparam int unsigned PIX = WPF * 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         hdr_last_frame;
    logic         ram_busy;
    logic         rd_req;
    logic [24:0]  rd_address;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         pixel_req;
    logic         pixel_valid;
    logic [4:0]   pixel_red;
    logic [5:0]   pixel_green;
    logic [4:0]   pixel_blue;
    logic         underflow;
    logic         frame_done;

    always #5 clk = ~clk;

    hdr_frame_reader #(
        .WordsPerFrame (WPF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .hdr_last_frame (hdr_last_frame),
        .ram_busy       (ram_busy),
        .rd_req         (rd_req),
        .rd_address     (rd_address),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .pixel_req      (pixel_req),
        .pixel_valid    (pixel_valid),
        .pixel_red      (pixel_red),
        .pixel_green    (pixel_green),
        .pixel_blue     (pixel_blue),
        .underflow      (underflow),
        .frame_done     (frame_done)
    );

    typedef struct {
        int gen;
        int due;
    } req_t;

    req_t         req_q[$];
    logic [127:0] force_q[$];
    logic [15:0]  exp_pix[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen = 0;
    int nreq = 0;
    int npix = 0;
    int ndone = 0;
    int ndrop = 0;
    int lat_min = 3;
    int lat_max = 3;
    int last_due = 0;
    int resp_gen = 0;
    logic [24:0] cur_base = 25'hE1000;
    logic [24:0] seen_addr = '0;
    logic [24:0] last_addr = '0;
    logic        seen_req = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Pixel k of a word: hi byte = bits [16k+7:16k], lo byte = bits [16k+15:16k+8].
    function automatic logic [15:0] expect_pixel(input logic [127:0] w, input int k);
        logic [127:0] s;
        logic [7:0]   hi;
        logic [7:0]   lo;
        s  = w >> (16 * k);
        hi = s[7:0];
        lo = s[15:8];
        return {hi[7:3], hi[2:0], lo[7:5], lo[4:0]};
    endfunction

    task automatic tick();
        int           old_pending;
        int           d;
        req_t         r;
        logic [15:0]  got;
        @(negedge clk);
        seen_req  = rd_req;
        seen_addr = rd_address;
        if (rd_valid && (resp_gen == gen)) begin
            for (int k = 0; k < 8; k++) exp_pix.push_back(expect_pixel(rd_data, k));
        end
        if (rd_valid && (resp_gen != gen)) ndrop++;
        if (ram_busy) check("busy_no_req", rd_req, 1'b0);
        if (rd_req) begin
            old_pending = 0;
            foreach (req_q[i]) if (req_q[i].gen != gen) old_pending++;
            check("rd_address", rd_address, 25'(cur_base + 25'(4 * nreq)));
            check("req_within_frame", nreq < WPF, 1'b1);
            check("no_old_in_flight", old_pending == 0, 1'b1);
            check("credit_limit", (req_q.size() + int'(rd_valid)) < 4, 1'b1);
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d < last_due) d = last_due;
            last_due = d;
            req_q.push_back('{gen: gen, due: d});
            last_addr = rd_address;
            nreq++;
        end
        @(posedge clk);
        #1;
        cyc++;
        got = {pixel_red, pixel_green, pixel_blue};
        if (pixel_valid) begin
            npix++;
            check("pixel_expected", exp_pix.size() != 0, 1'b1);
            if (exp_pix.size() != 0) check("pixel_rgb", got, exp_pix.pop_front());
        end
        if (frame_done) begin
            ndone++;
            check("done_with_last_pixel", pixel_valid && (npix == PIX), 1'b1);
        end
        rd_valid = 1'b0;
        rd_data  = '0;
        if ((req_q.size() != 0) && (req_q[0].due <= cyc)) begin
            r        = req_q.pop_front();
            rd_valid = 1'b1;
            resp_gen = r.gen;
            if ((r.gen == gen) && (force_q.size() != 0)) rd_data = force_q.pop_front();
            else rd_data = {$urandom, $urandom, $urandom, $urandom};
        end
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input logic h);
        hdr_last_frame = h;
        frame_start    = 1'b1;
        gen++;
        cur_base = h ? 25'hE1000 : 25'h106800;
        nreq  = 0;
        npix  = 0;
        ndone = 0;
        ndrop = 0;
        exp_pix.delete();
        tick();
    endtask

    task automatic run_to_done(input int busy_pct, input int req_pct, input int budget);
        for (int i = 0; (i < budget) && (ndone == 0); i++) begin
            ram_busy  = ($urandom_range(99) < busy_pct);
            pixel_req = ($urandom_range(99) < req_pct);
            tick();
        end
        ram_busy  = 1'b0;
        pixel_req = 1'b0;
        check("frame_done_seen", ndone, 1);
        check("pixel_count", npix, PIX);
        check("request_count", nreq, WPF);
        check("last_address", last_addr, 25'(cur_base + 25'(4 * (WPF - 1))));
        check("no_underflow", underflow, 1'b0);
        repeat (12) tick();
        check("idle_no_more_req", nreq, WPF);
        check("single_done", ndone, 1);
    endtask

    initial begin
        logic [127:0] w;
        logic [24:0]  first_a;
        int           got;

        rst = 1'b1;
        frame_start = 1'b0;
        hdr_last_frame = 1'b1;
        ram_busy = 1'b0;
        rd_valid = 1'b0;
        rd_data = '0;
        pixel_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_rd_address", rd_address, 25'hE1000);
        check("rst_pixel_valid", pixel_valid, 1'b0);
        check("rst_pixels", {pixel_red, pixel_green, pixel_blue}, 16'h0000);
        check("rst_underflow", underflow, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        tick();

        // Buffer 0, slow memory: credit caps the burst at four requests.
        lat_min = 10;
        lat_max = 10;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[15:0] = 16'h1FF8;
        force_q.push_back(w);
        w = {$urandom, $urandom, $urandom, $urandom};
        w[15:0] = 16'hE007;
        force_q.push_back(w);
        start_frame(1'b1);
        got = 0;
        first_a = '0;
        for (int i = 0; (i < 60) && !rd_valid; i++) begin
            tick();
            if (seen_req) begin
                if (got == 0) first_a = seen_addr;
                got++;
            end
        end
        check("first_response_arrived", rd_valid, 1'b1);
        check("credit_burst_of_4", got, 4);
        check("first_addr_buf0", first_a, 25'hE1000);
        repeat (20) tick();

        // Directed unpack: magenta, then after the 8th pixel the next word's green.
        pixel_req = 1'b1;
        tick();
        check("px0_valid", pixel_valid, 1'b1);
        check("px0_rgb", {pixel_red, pixel_green, pixel_blue}, {5'h1F, 6'h00, 5'h1F});
        repeat (7) tick();
        tick();
        check("px8_valid", pixel_valid, 1'b1);
        check("px8_from_word1", {pixel_red, pixel_green, pixel_blue}, {5'h00, 6'h3F, 5'h00});
        check("no_underflow_yet", underflow, 1'b0);

        // Starve the FIFO to force an underflow.
        ram_busy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!pixel_valid) break;
        end
        pixel_req = 1'b0;
        check("underflow_set", underflow, 1'b1);
        check("underflow_no_valid", pixel_valid, 1'b0);
        check("underflow_zero_px", {pixel_red, pixel_green, pixel_blue}, 16'h0000);
        for (int i = 0; (i < 100) && (req_q.size() != 0); i++) tick();
        check("drained", req_q.size(), 0);

        // Buffer 1, then restart with two responses still in flight.
        ram_busy = 1'b0;
        start_frame(1'b0);
        check("underflow_cleared", underflow, 1'b0);
        got = 0;
        for (int i = 0; (i < 20) && (got < 2); i++) begin
            tick();
            if (seen_req) begin
                if (got == 0) first_a = seen_addr;
                got++;
            end
        end
        check("two_requests", got, 2);
        check("first_addr_buf1", first_a, 25'h106800);
        start_frame(1'b1);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (seen_req) break;
        end
        check("restart_req_issued", seen_req, 1'b1);
        check("drops_before_new_req", ndrop, 2);
        check("restart_addr", seen_addr, 25'hE1000);
        tick();
        check("second_req", seen_req, 1'b1);
        check("second_addr", seen_addr, 25'hE1004);

        // RAM busy for five cycles mid-fill: request held, no address skipped.
        ram_busy = 1'b1;
        repeat (5) tick();
        ram_busy = 1'b0;
        tick();
        check("req_after_busy", seen_req, 1'b1);
        check("addr_after_busy", seen_addr, 25'hE1008);

        // Finish this frame with latency 3 and continuous pixel_req.
        lat_min = 3;
        lat_max = 3;
        run_to_done(10, 100, 3000);

        // Random latency, random demand, buffer 1.
        lat_min = 1;
        lat_max = 6;
        start_frame(1'b0);
        run_to_done(20, 70, 4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
